mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side responder for the processor pool's read/write request interface.
- Accepts per-processor read and write requests and arbitrates them round-robin.
- Drives a single-port 128-bit data memory, one access per transaction.
- Returns a one-cycle grant to the winner; for reads, follows it with a one-cycle valid plus read data on a shared bus.

Parameters:
- N_PROC, 4: number of requesting processors (matches pool processor count).
- ADDR_W, 16: word address width; one address = one 128-bit memory line.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_req_rd  in  N_PROC  per-processor read request, level, held until granted.
- i_req_wr  in  N_PROC  per-processor write request, level, held until granted.
- i_addr  in  N_PROC x ADDR_W  per-processor address, unpacked array.
- i_data  in  N_PROC x 128  per-processor write data, unpacked array.
- i_wr_size  in  N_PROC x 3  per-processor write size in 32-bit words.
- o_grant_rd  out  N_PROC  one-hot read grant pulse.
- o_grant_wr  out  N_PROC  one-hot write grant pulse.
- o_valid  out  N_PROC  one-hot read-data-valid pulse.
- o_data  out  128  shared read data, meaningful only with o_valid.
- o_mem_en  out  1  memory access enable.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  128  memory write data.
- o_mem_wmask  out  4  per-32-bit-word write mask; bit k covers bits [32k+31:32k].
- i_mem_rdata  in  128  memory read data, valid one cycle after a read enable.

Behaviour:
- Reset: state IDLE; round-robin pointer 0; all outputs 0, o_data included.
- States: IDLE, GRANT, RESP.
- IDLE:
  - Per processor, a request is pending if i_req_rd or i_req_wr is set.
  - Winner = first pending processor searching from the pointer upward, wrapping at N_PROC-1 -> 0.
  - Register the winner index and the type: write if i_req_wr is set (write beats read within one processor), else read.
  - Go to GRANT. No request: stay in IDLE.
- GRANT, exactly one cycle:
  - Assert the o_grant_wr or o_grant_rd bit of the winner.
  - o_mem_en=1; o_mem_addr = i_addr[winner], taken combinationally this cycle.
  - Write:
    - o_mem_we=1; o_mem_wdata = i_data[winner].
    - o_mem_wmask from i_wr_size[winner]: 0 -> 0000, 1 -> 0001, 2 -> 0011, 3 -> 0111, 4..7 -> 1111.
    - Next state IDLE.
  - Read: o_mem_we=0; o_mem_wmask=0; next state RESP.
  - Pointer <= winner+1 modulo N_PROC.
- RESP, one cycle: o_valid[winner]=1; o_data = i_mem_rdata; next state IDLE.
- o_mem_en, o_mem_we, o_mem_wmask are 0 outside GRANT.
- Throughput: write = 2 cycles per transaction (IDLE+GRANT); read = 3 cycles, grant-to-valid latency 1.
- Requests are sampled only in IDLE; requests arriving in GRANT/RESP wait.
- A requester dropping its request after the arbiter has left IDLE is ignored; the transaction completes.
- At most one bit set across o_grant_rd, o_grant_wr and o_valid in any cycle.
- Async reset mid-transaction aborts it: no valid is issued, pointer returns to 0.

Optional Feature:
- Macro: MEM_ARBITER_PERF_CNT_EN.
- Defined:
  - Adds outputs o_rd_cnt (32) and o_wr_cnt (32).
  - Each increments on every GRANT cycle of its type.
  - Each saturates at 0xFFFFFFFF.
  - Both reset to 0.
- Undefined: both ports and all counter logic absent; behaviour otherwise identical.

Test Plan:
- Single read: proc 2 raises i_req_rd, i_addr[2]=0x0010, memory holds 0xA5..A5 at 0x10 -> o_grant_rd=0100 on cycle 1 with mem_en=1 and mem_we=0; o_valid=0100 with o_data=0xA5..A5 on cycle 2.
- Partial write: proc 0 i_req_wr, i_wr_size=2, i_addr=0x3 -> o_grant_wr=0001, o_mem_we=1, o_mem_wmask=0011, o_mem_addr=0x3; no o_valid pulse.
- Round-robin fairness: all 4 procs hold i_req_rd continuously from reset -> grant order 0,1,2,3,0; each grant 3 cycles apart.
- Same-processor conflict: proc 1 raises both i_req_rd and i_req_wr -> write granted first; after proc 1 drops i_req_wr, read granted on a later IDLE pass.
- Size edge cases: i_wr_size=0 -> grant issued with mask 0000; i_wr_size=7 -> mask 1111.
- Reset mid-read: assert i_rstn=0 during GRANT of a read -> all outputs 0 immediately; no o_valid afterwards; next arbitration starts at proc 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/memory bundle for mem_arbiter.
// slave = arbiter side, master = processor pool and memory side.
interface mem_arbiter_if #(
    parameter int N_PROC = 4,
    parameter int ADDR_W = 16
);
    logic [N_PROC-1:0] i_req_rd;
    logic [N_PROC-1:0] i_req_wr;
    logic [ADDR_W-1:0] i_addr    [N_PROC];
    logic [127:0]      i_data    [N_PROC];
    logic [2:0]        i_wr_size [N_PROC];
    logic [N_PROC-1:0] o_grant_rd;
    logic [N_PROC-1:0] o_grant_wr;
    logic [N_PROC-1:0] o_valid;
    logic [127:0]      o_data;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [127:0]      o_mem_wdata;
    logic [3:0]        o_mem_wmask;
    logic [127:0]      i_mem_rdata;

    modport slave (
        input  i_req_rd, i_req_wr, i_addr, i_data, i_wr_size,
        input  i_mem_rdata,
        output o_grant_rd, o_grant_wr, o_valid, o_data,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );

    modport master (
        output i_req_rd, i_req_wr, i_addr, i_data, i_wr_size,
        output i_mem_rdata,
        input  o_grant_rd, o_grant_wr, o_valid, o_data,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin read/write arbiter in front of a 128-bit single-port memory.
// Optional MEM_ARBITER_PERF_CNT_EN adds saturating read/write grant counters.
module mem_arbiter #(
    parameter int N_PROC = 4,
    parameter int ADDR_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_PERF_CNT_EN
    ,
    output logic [31:0] o_rd_cnt,
    output logic [31:0] o_wr_cnt
`endif
);
    localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RESP
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic              is_wr;
    logic [N_PROC-1:0] pend;
    logic              found;
    logic [PW-1:0]     pick;
    logic [N_PROC-1:0] win_oh;
    logic [N_PROC-1:0] pick_oh;
    logic              in_grant;
    int                k;

    assign pend     = bus.i_req_rd | bus.i_req_wr;
    assign win_oh   = N_PROC'(1) << win;
    assign pick_oh  = N_PROC'(1) << pick;
    assign in_grant = (state == GRANT);

    // First pending requester at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        k     = 0;
        for (int i = 0; i < N_PROC; i++) begin
            k = int'(ptr) + i;
            if (k >= N_PROC) k = k - N_PROC;
            if (!found && pend[k]) begin
                found = 1'b1;
                pick  = PW'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= IDLE;
            ptr            <= '0;
            win            <= '0;
            is_wr          <= 1'b0;
            bus.o_grant_rd <= '0;
            bus.o_grant_wr <= '0;
            bus.o_valid    <= '0;
            bus.o_mem_en   <= 1'b0;
            bus.o_mem_we   <= 1'b0;
        end else begin
            bus.o_grant_rd <= '0;
            bus.o_grant_wr <= '0;
            bus.o_valid    <= '0;
            bus.o_mem_en   <= 1'b0;
            bus.o_mem_we   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        win          <= pick;
                        is_wr        <= bus.i_req_wr[pick];
                        state        <= GRANT;
                        bus.o_mem_en <= 1'b1;
                        bus.o_mem_we <= bus.i_req_wr[pick];
                        if (bus.i_req_wr[pick])
                            bus.o_grant_wr <= pick_oh;
                        else
                            bus.o_grant_rd <= pick_oh;
                    end
                end
                GRANT: begin
                    if (win == PW'(N_PROC - 1))
                        ptr <= '0;
                    else
                        ptr <= win + PW'(1);
                    if (is_wr) begin
                        state <= IDLE;
                    end else begin
                        state       <= RESP;
                        bus.o_valid <= win_oh;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Address, data and mask follow the winner's live inputs during GRANT.
    assign bus.o_mem_addr  = in_grant ? bus.i_addr[win] : '0;
    assign bus.o_mem_wdata = (in_grant && is_wr) ? bus.i_data[win] : '0;
    assign bus.o_data      = (state == RESP) ? bus.i_mem_rdata : '0;

    always_comb begin
        bus.o_mem_wmask = 4'b0000;
        if (in_grant && is_wr) begin
            unique case (bus.i_wr_size[win])
                3'd0:    bus.o_mem_wmask = 4'b0000;
                3'd1:    bus.o_mem_wmask = 4'b0001;
                3'd2:    bus.o_mem_wmask = 4'b0011;
                3'd3:    bus.o_mem_wmask = 4'b0111;
                default: bus.o_mem_wmask = 4'b1111;
            endcase
        end
    end

`ifdef MEM_ARBITER_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rd_cnt <= '0;
            o_wr_cnt <= '0;
        end else if (in_grant) begin
            if (is_wr && o_wr_cnt != '1) o_wr_cnt <= o_wr_cnt + 32'd1;
            if (!is_wr && o_rd_cnt != '1) o_rd_cnt <= o_rd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
    localparam int NP = 4;
    localparam int AW = 16;

    logic clk;
    logic rstn;
    int   errs;
    int   checks;
    int   cyc;
    logic [127:0] mem [0:63];
    logic [127:0] rdata;
    logic [127:0] dw;
    logic [127:0] de;
    logic [NP-1:0] vsum;
    bit   ok;
    int   last_t;
`ifdef MEM_ARBITER_PERF_CNT_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
`endif

    mem_arbiter_if #(.N_PROC(NP), .ADDR_W(AW)) bus ();

    mem_arbiter #(.N_PROC(NP), .ADDR_W(AW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
`ifdef MEM_ARBITER_PERF_CNT_EN
        ,
        .o_rd_cnt (rd_cnt),
        .o_wr_cnt (wr_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears one cycle after enable.
    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_we) begin
                for (int w = 0; w < 4; w++)
                    if (bus.o_mem_wmask[w])
                        mem[bus.o_mem_addr[5:0]][32*w +: 32] <=
                            bus.o_mem_wdata[32*w +: 32];
            end else begin
                rdata <= mem[bus.o_mem_addr[5:0]];
            end
        end
    end
    assign bus.i_mem_rdata = rdata;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (|(bus.o_grant_rd | bus.o_grant_wr)) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("grant_timeout", 0, 1);
    endtask

    initial begin
        errs = 0;
        checks = 0;
        cyc = 0;
        rdata = '0;
        dw = {4{32'hDEAD_BEEF}};
        de = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[16] = {16{8'hA5}};
        rstn = 1'b0;
        bus.i_req_rd = '0;
        bus.i_req_wr = '0;
        for (int i = 0; i < NP; i++) begin
            bus.i_addr[i] = '0;
            bus.i_data[i] = '0;
            bus.i_wr_size[i] = '0;
        end

        repeat (2) @(negedge clk);
        chk("rst_grant_rd", 128'(bus.o_grant_rd), 0);
        chk("rst_grant_wr", 128'(bus.o_grant_wr), 0);
        chk("rst_valid", 128'(bus.o_valid), 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_mem", {bus.o_mem_en, bus.o_mem_we,
                        bus.o_mem_wmask, bus.o_mem_addr}, 0);
`ifdef MEM_ARBITER_PERF_CNT_EN
        chk("rst_cnt", {rd_cnt, wr_cnt}, 0);
`endif
        rstn = 1'b1;

        // Single read by proc 2
        bus.i_req_rd[2] = 1'b1;
        bus.i_addr[2] = 16'h0010;
        @(negedge clk);
        chk("rd_grant", 128'(bus.o_grant_rd), 4'b0100);
        chk("rd_en_we", {bus.o_mem_en, bus.o_mem_we}, 2'b10);
        chk("rd_addr", 128'(bus.o_mem_addr), 16'h0010);
        bus.i_req_rd[2] = 1'b0;
        @(negedge clk);
        chk("rd_valid", 128'(bus.o_valid), 4'b0100);
        chk("rd_data", bus.o_data, {16{8'hA5}});
        chk("rd_grant_off", 128'(bus.o_grant_rd), 0);
        @(negedge clk);
        chk("rd_valid_off", 128'(bus.o_valid), 0);

        // Partial write by proc 0, size 2
        bus.i_req_wr[0] = 1'b1;
        bus.i_wr_size[0] = 3'd2;
        bus.i_addr[0] = 16'h0003;
        bus.i_data[0] = dw;
        @(negedge clk);
        chk("wr_grant", 128'(bus.o_grant_wr), 4'b0001);
        chk("wr_we", {bus.o_mem_en, bus.o_mem_we}, 2'b11);
        chk("wr_mask2", 128'(bus.o_mem_wmask), 4'b0011);
        chk("wr_addr", 128'(bus.o_mem_addr), 16'h0003);
        chk("wr_wdata", bus.o_mem_wdata, dw);
        bus.i_req_wr[0] = 1'b0;
        @(negedge clk);
        chk("wr_no_valid", 128'(bus.o_valid), 0);
        chk("wr_en_off", 128'(bus.o_mem_en), 0);
        chk("wr_mem", mem[3], {64'h0, dw[63:0]});

        // Size edges: proc 1 size 0, then proc 2 size 7
        bus.i_req_wr[1] = 1'b1;
        bus.i_wr_size[1] = 3'd0;
        bus.i_addr[1] = 16'h0005;
        bus.i_data[1] = dw;
        @(negedge clk);
        chk("sz0_grant", 128'(bus.o_grant_wr), 4'b0010);
        chk("sz0_mask", 128'(bus.o_mem_wmask), 4'b0000);
        bus.i_req_wr[1] = 1'b0;
        @(negedge clk);
        chk("sz0_mem", mem[5], 0);
        bus.i_req_wr[2] = 1'b1;
        bus.i_wr_size[2] = 3'd7;
        bus.i_addr[2] = 16'h0006;
        bus.i_data[2] = de;
        @(negedge clk);
        chk("sz7_grant", 128'(bus.o_grant_wr), 4'b0100);
        chk("sz7_mask", 128'(bus.o_mem_wmask), 4'b1111);
        bus.i_req_wr[2] = 1'b0;
        @(negedge clk);
        chk("sz7_mem", mem[6], de);

        // Proc 1 asks for both: write first, read later
        bus.i_req_rd[1] = 1'b1;
        bus.i_req_wr[1] = 1'b1;
        bus.i_wr_size[1] = 3'd4;
        bus.i_addr[1] = 16'h0010;
        @(negedge clk);
        chk("cf_wr_first", {bus.o_grant_wr, bus.o_grant_rd}, 8'b0010_0000);
        bus.i_req_wr[1] = 1'b0;
        wait_grant(ok);
        chk("cf_rd_later", {bus.o_grant_wr, bus.o_grant_rd}, 8'b0000_0010);
        bus.i_req_rd[1] = 1'b0;
        @(negedge clk);
        chk("cf_valid", 128'(bus.o_valid), 4'b0010);
        @(negedge clk);

        // Round robin from reset, all four reading
        rstn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NP; i++) bus.i_addr[i] = 16'h0010;
        bus.i_req_rd = '1;
        rstn = 1'b1;
        last_t = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant(ok);
            chk($sformatf("rr_order%0d", g), 128'(bus.o_grant_rd),
                128'(4'b0001 << (g % 4)));
            if (g > 0) chk($sformatf("rr_gap%0d", g), 128'(cyc - last_t), 3);
            last_t = cyc;
        end
        bus.i_req_rd = '0;
        repeat (2) @(negedge clk);

        // Reset during a read grant aborts it and rewinds the pointer
        bus.i_req_rd[2] = 1'b1;
        @(negedge clk);
        chk("mr_grant", 128'(bus.o_grant_rd), 4'b0100);
        rstn = 1'b0;
        #1;
        chk("mr_outs", {bus.o_grant_rd, bus.o_grant_wr, bus.o_valid,
                        bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr}, 0);
        bus.i_req_rd[2] = 1'b0;
        vsum = '0;
        repeat (2) begin
            @(negedge clk);
            vsum |= bus.o_valid;
        end
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vsum |= bus.o_valid;
        end
        chk("mr_no_valid", 128'(vsum), 0);
        bus.i_req_rd[0] = 1'b1;
        bus.i_req_rd[3] = 1'b1;
        wait_grant(ok);
        chk("mr_ptr0", 128'(bus.o_grant_rd), 4'b0001);
        bus.i_req_rd = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
